// File: rtl/dvi_rx_decode_if.sv
// rtl/dvi_rx_decode_if.sv - symbol and decoded-output bundle for one TMDS channel
//
// in_d        : raw 10-bit symbol from the deserializer, bit 0 transmitted first
// out_de      : 1 = data period, 0 = control period
// out_d       : decoded pixel byte, meaningful when out_de=1
// out_c0/c1   : decoded control bits, meaningful when out_de=0
// out_bitslip : one-cycle request for a one-bit slip in the deserializer
// out_locked  : word alignment achieved
//
// master : the deserializer/consumer side (drives in_d, receives decoded outputs)
// slave  : the decoder

interface dvi_rx_decode_if;
  logic [9:0] in_d;
  logic       out_de;
  logic [7:0] out_d;
  logic       out_c0;
  logic       out_c1;
  logic       out_bitslip;
  logic       out_locked;

  modport master (
    output in_d,
    input  out_de,
    input  out_d,
    input  out_c0,
    input  out_c1,
    input  out_bitslip,
    input  out_locked
  );

  modport slave (
    input  in_d,
    output out_de,
    output out_d,
    output out_c0,
    output out_c1,
    output out_bitslip,
    output out_locked
  );
endinterface

// File: rtl/dvi_rx_decode.sv
// rtl/dvi_rx_decode.sv - TMDS channel decoder with word-alignment state machine
//
// clk   : pixel clock, rising edge
// reset : asynchronous active-low reset
// bus   : dvi_rx_decode_if.slave (in_d in; out_de, out_d, out_c0, out_c1,
//         out_bitslip, out_locked out)
//
// Two-stage decode pipeline (in_d -> outputs in exactly 2 cycles) runs
// independently of lock. The alignment FSM watches the stage-1 token flag.

module dvi_rx_decode #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int BITSLIP_WAIT   = 16,
  parameter int LOSS_TIMEOUT   = 1048575
) (
  input  logic            clk,
  input  logic            reset,
  dvi_rx_decode_if.slave  bus
);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  localparam logic [7:0]  LOCK_CNT    = 8'(LOCK_COUNT);
  localparam logic [19:0] SEARCH_LAST = 20'(SEARCH_TIMEOUT - 1);
  localparam logic [19:0] SLIP_LAST   = 20'(BITSLIP_WAIT - 1);
  localparam logic [19:0] LOSS_LAST   = 20'(LOSS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Stage 1: register the symbol together with its token classification
  // ---------------------------------------------------------------------------
  logic       tok_hit;
  logic [1:0] tok_idx;

  always_comb begin
    tok_hit = 1'b1;
    tok_idx = 2'b00;
    case (bus.in_d)
      TOK_00:  tok_idx = 2'b00;
      TOK_01:  tok_idx = 2'b01;
      TOK_10:  tok_idx = 2'b10;
      TOK_11:  tok_idx = 2'b11;
      default: tok_hit = 1'b0;
    endcase
  end

  logic [9:0] s1_d;
  logic       s1_hit;
  logic [1:0] s1_idx;
  logic       s1_vld;

  // s1_vld keeps the zeroed pipeline from reaching the outputs right after
  // reset; the first real decode lands two cycles after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_d   <= 10'd0;
      s1_hit <= 1'b0;
      s1_idx <= 2'b00;
      s1_vld <= 1'b0;
    end else begin
      s1_d   <= bus.in_d;
      s1_hit <= tok_hit;
      s1_idx <= tok_idx;
      s1_vld <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: decoded outputs
  // ---------------------------------------------------------------------------
  // bit 9 undoes the DC-balance inversion, bit 8 selects XOR vs XNOR chaining.
  function automatic logic [7:0] tmds_data(input logic [9:0] sym);
    logic [7:0] q;
    logic [7:0] d;
    q    = sym[9] ? ~sym[7:0] : sym[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  logic       de_q;
  logic [7:0] d_q;
  logic       c0_q;
  logic       c1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_q <= 1'b0;
      d_q  <= 8'h00;
      c0_q <= 1'b0;
      c1_q <= 1'b0;
    end else if (s1_vld) begin
      if (s1_hit) begin
        de_q <= 1'b0;
        d_q  <= 8'h00;
        c1_q <= s1_idx[1];
        c0_q <= s1_idx[0];
      end else begin
        // control bits hold their last value through data periods
        de_q <= 1'b1;
        d_q  <= tmds_data(s1_d);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word-alignment FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_n;
  logic [7:0]  tok_cnt_q, tok_cnt_n;
  logic [19:0] timer_q, timer_n;
  logic        bitslip_q;
  logic        locked_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SEARCH;
      tok_cnt_q <= 8'd0;
      timer_q   <= 20'd0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      tok_cnt_q <= tok_cnt_n;
      timer_q   <= timer_n;
      // pulse only on the SEARCH->SLIP transition, i.e. first cycle of SLIP
      bitslip_q <= (state_q == ST_SEARCH) && (state_n == ST_SLIP);
      locked_q  <= (state_n == ST_LOCKED);
    end
  end

  // One timer serves all three states: search timeout, slip settle time and
  // loss-of-lock timeout. It is cleared on every state change, so each state
  // starts counting from zero. Limits are checked with == before incrementing,
  // so the timer can never wrap.
  always_comb begin
    state_n   = state_q;
    tok_cnt_n = tok_cnt_q;
    timer_n   = timer_q;
    case (state_q)
      ST_SEARCH: begin
        if (tok_cnt_q == LOCK_CNT) begin
          // lock takes priority over a simultaneous search timeout
          state_n   = ST_LOCKED;
          tok_cnt_n = 8'd0;
          timer_n   = 20'd0;
        end else if (timer_q == SEARCH_LAST) begin
          state_n   = ST_SLIP;
          tok_cnt_n = 8'd0;
          timer_n   = 20'd0;
        end else begin
          timer_n   = timer_q + 20'd1;
          // tok_cnt is below LOCK_CNT here, so the increment saturates at it
          tok_cnt_n = s1_hit ? tok_cnt_q + 8'd1 : 8'd0;
        end
      end
      ST_SLIP: begin
        // symbols are ignored while the deserializer settles after the slip
        if (timer_q == SLIP_LAST) begin
          state_n   = ST_SEARCH;
          tok_cnt_n = 8'd0;
          timer_n   = 20'd0;
        end else begin
          timer_n = timer_q + 20'd1;
        end
      end
      ST_LOCKED: begin
        if (s1_hit) begin
          timer_n = 20'd0;
        end else if (timer_q == LOSS_LAST) begin
          state_n   = ST_SEARCH;
          tok_cnt_n = 8'd0;
          timer_n   = 20'd0;
        end else begin
          timer_n = timer_q + 20'd1;
        end
      end
      default: begin
        state_n   = ST_SEARCH;
        tok_cnt_n = 8'd0;
        timer_n   = 20'd0;
      end
    endcase
  end

  assign bus.out_de      = de_q;
  assign bus.out_d       = d_q;
  assign bus.out_c0      = c0_q;
  assign bus.out_c1      = c1_q;
  assign bus.out_bitslip = bitslip_q;
  assign bus.out_locked  = locked_q;

endmodule

// File: tb/tb_dvi_rx_decode.sv
// tb/tb_dvi_rx_decode.sv - directed self-checking bench for dvi_rx_decode

module tb_dvi_rx_decode;

  localparam int LOSS_T = 1000;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;

  dvi_rx_decode_if bus ();

  dvi_rx_decode #(
    .LOCK_COUNT    (8),
    .SEARCH_TIMEOUT(4096),
    .BITSLIP_WAIT  (16),
    .LOSS_TIMEOUT  (LOSS_T)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one symbol, advance one clock, land 1 time unit after the edge
  task automatic tick(input logic [9:0] v);
    bus.in_d = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [9:0] tmds_enc(input logic [7:0] d, input logic inv);
    logic [8:0] qm;
    int n1;
    n1    = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  logic [9:0] sym_tab [512];
  logic [7:0] exp_tab [512];

  initial begin
    int n;
    int m;
    logic any_lock;
    n_cmp    = 0;
    n_mis    = 0;
    reset    = 1'b0;
    bus.in_d = 10'h3A5;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {bus.out_de, bus.out_d, bus.out_c1, bus.out_c0, bus.out_bitslip, bus.out_locked},
        32'd0);

    // release, first decode appears exactly two cycles later
    reset = 1'b1;
    tick(10'h100);
    chk("latency_1cyc_de", bus.out_de, 1'b0);
    tick(10'h100);
    chk("dec_100", {bus.out_de, bus.out_d}, {1'b1, 8'h00});
    tick(10'h200);
    tick(10'h200);
    chk("dec_200", {bus.out_de, bus.out_d}, {1'b1, 8'hFF});

    // all bytes, both polarities, streamed back to back
    for (int k = 0; k < 512; k++) begin
      exp_tab[k] = k[7:0];
      sym_tab[k] = tmds_enc(k[7:0], k[8]);
    end
    for (int k = 0; k < 514; k++) begin
      tick(k < 512 ? sym_tab[k] : 10'h100);
      if (k >= 1) chk("byte_rt", {bus.out_de, bus.out_d}, {1'b1, exp_tab[k-1]});
    end

    // lock: 8 consecutive 00 tokens, lock 10 cycles after the first
    do_reset();
    for (int t = 1; t <= 12; t++) begin
      tick(T00);
      chk("lock_timing", bus.out_locked, (t >= 10) ? 1'b1 : 1'b0);
    end
    chk("tok00_decode", {bus.out_de, bus.out_c1, bus.out_c0}, 3'b000);
    tick(T11);
    tick(T11);
    chk("tok11_decode", {bus.out_de, bus.out_c1, bus.out_c0}, 3'b011);
    tick(10'h200);
    tick(10'h200);
    chk("ctl_hold_in_data", {bus.out_de, bus.out_d, bus.out_c1, bus.out_c0},
        {1'b1, 8'hFF, 2'b11});

    // loss of lock after LOSS_T token-free cycles
    repeat (3) tick(T00);
    n = 0;
    while (bus.out_locked && n < 3 * LOSS_T) begin
      tick(10'h200);
      n++;
    end
    chk("loss_cycles", n, LOSS_T + 1);

    // interrupted run: 7 tokens, 1 data, 8 tokens
    do_reset();
    for (int t = 1; t <= 20; t++) begin
      if (t == 8) tick(10'h200);
      else tick(T00);
      chk("lock_interrupted", bus.out_locked, (t >= 18) ? 1'b1 : 1'b0);
    end

    // reset while locked, then relock from scratch
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_outputs",
        {bus.out_de, bus.out_d, bus.out_c1, bus.out_c0, bus.out_bitslip, bus.out_locked},
        32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick(T00);
      if (t >= 9) chk("relock", bus.out_locked, (t >= 10) ? 1'b1 : 1'b0);
    end

    // bitslip spacing with constant data in SEARCH
    do_reset();
    any_lock = 1'b0;
    n = 0;
    while (!bus.out_bitslip && n < 5000) begin
      tick(10'h100);
      any_lock |= bus.out_locked;
      n++;
    end
    chk("bitslip_first", n, 4096);
    tick(10'h100);
    chk("bitslip_width", bus.out_bitslip, 1'b0);
    m = 1;
    while (!bus.out_bitslip && m < 6000) begin
      tick(10'h100);
      any_lock |= bus.out_locked;
      m++;
    end
    chk("bitslip_second", m, 4112);
    chk("no_lock_in_slip", any_lock, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dvi_rx_decode.md
Name: dvi_rx_decode

Overview:
- TMDS channel decoder. It is the receive-side counterpart of the DVI transmit encoder and handles one colour channel.
- Takes parallel 10-bit symbols from the deserializer and recovers DE, 8-bit data and C0/C1.
- Contains a word-alignment state machine that requests bitslips from the deserializer until control tokens are found consistently, then reports lock.
- Instantiated once per TMDS channel, downstream of the ISERDES/bitslip logic.

Parameters:
- LOCK_COUNT, 8: consecutive control tokens required to declare lock (valid range 1..255).
- SEARCH_TIMEOUT, 4096: cycles spent in SEARCH before a bitslip is requested (valid range 2..2^20-1).
- BITSLIP_WAIT, 16: cycles ignored after a bitslip pulse while the deserializer settles (valid range 1..2^20-1).
- LOSS_TIMEOUT, 1048575: cycles in LOCKED without any control token before lock is dropped (valid range 1..2^20-1).

Ports:
- clk input 1: pixel clock; all logic is on the rising edge.
- reset input 1: reset, active-low, asynchronous assert.
- in_d input 10: raw symbol from the deserializer; bit 0 is the first transmitted bit.
- out_de output 1: 1 = data period, 0 = control period.
- out_d output 8: decoded pixel data; valid when out_de=1.
- out_c0 output 1: decoded control bit 0; valid when out_de=0.
- out_c1 output 1: decoded control bit 1; valid when out_de=0.
- out_bitslip output 1: single-cycle pulse requesting a one-bit slip from the deserializer.
- out_locked output 1: word alignment achieved.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, reset).
- Reset values: all outputs 0, FSM in SEARCH, all counters 0.
- Control tokens, in {c1,c0} order:
  - 00 = 10'b1101010100
  - 01 = 10'b0010101011
  - 10 = 10'b0101010100
  - 11 = 10'b1010101011
- Pipeline, latency exactly 2 cycles from in_d to out_de/out_d/out_c0/out_c1:
  - Stage 1 registers in_d, a token-hit flag and the 2-bit token index.
  - Stage 2 registers the decoded outputs.
- Token symbol decode: out_de=0, {out_c1,out_c0}=index, out_d=8'h00.
- Any other symbol: out_de=1, out_c0/out_c1 hold their last control values.
  - q = in_d[9] ? ~in_d[7:0] : in_d[7:0].
  - out_d[0] = q[0].
  - For i = 1..7: out_d[i] = in_d[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
- The decode path runs regardless of lock state; consumers gate it with out_locked.
- The FSM runs on the stage-1 token flag, i.e. one cycle after in_d.
- SEARCH:
  - tok_cnt increments on a token and clears on a non-token.
  - timer increments every cycle.
  - When tok_cnt reaches LOCK_COUNT: go to LOCKED; out_locked=1 from the next cycle.
  - Otherwise, when timer reaches SEARCH_TIMEOUT-1: go to SLIP.
  - If lock and timeout occur on the same cycle, lock wins.
- SLIP:
  - out_bitslip=1 for exactly the first cycle of SLIP.
  - Input is ignored for BITSLIP_WAIT cycles, then the FSM returns to SEARCH with tok_cnt and timer cleared.
  - At most one pulse is issued per SLIP entry; pulses are therefore spaced at least SEARCH_TIMEOUT+BITSLIP_WAIT cycles apart.
- LOCKED:
  - The loss timer clears on every token and increments otherwise.
  - When it reaches LOSS_TIMEOUT: go to SEARCH, out_locked=0 the next cycle, counters cleared.
  - No bitslip is ever issued while LOCKED.
- Counter widths: 20 bits for the timers, 8 bits for tok_cnt.
  - tok_cnt saturates at LOCK_COUNT.
  - Timers never wrap, because they compare with == before incrementing past the limit.
- Reset asserted mid-operation: all state and outputs go to reset values immediately. Pipeline contents are discarded and the first decoded output appears 2 cycles after reset deasserts.

Test Plan:
- Reset: hold reset=0 with arbitrary in_d -> all outputs 0. Release and drive 10'h100 -> out_de=1, out_d=8'h00 two cycles later.
- Data decode: drive 10'h200 -> out_d=8'hFF, out_de=1. Exhaustively drive all 256 bytes through a reference encoder model (both DC-balance polarities) -> decoded byte equals source with 2-cycle latency.
- Lock: 8 consecutive 10'b1101010100 symbols -> out_locked rises 10 cycles after the first token; out_de=0, c1c0=00. Then 10'b1010101011 -> c1c0=11.
- Lock interrupted: 7 tokens, 1 data symbol, 8 tokens -> lock only after the second run completes; no early out_locked.
- Bitslip: constant 10'h100 in SEARCH -> out_bitslip pulses once after 4096 cycles, again 4096+16 cycles later; out_locked stays 0.
- Loss and reset: after lock, 1048575 cycles with no token -> out_locked falls. Separately, reset=0 while locked -> out_locked=0 immediately and relock needs 8 fresh tokens.
